// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int ZERO_IDX  = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle between decode/writeback (master) and the register file (slave).
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
) ();

  // No valid/ready pair: reads are combinational, writes and pending marks take
  // effect at the next rising edge, and all requests are dropped while init_busy=1.
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_pend;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         pend_set;
  logic [ADDR_WIDTH-1:0]        pend_addr;
  logic                         init_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    input  rd_data, rd_pend, init_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    output rd_data, rd_pend, init_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared by writeback, looked up per read port.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         pend_set,
  input  logic [ADDR_WIDTH-1:0]        pend_addr,
  input  logic [NUM_WR-1:0]            wr_ok,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_pend
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Clears first, then the set: a newly issued producer overrides the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (en) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) pend_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
      if (pend_set) pend_d[pend_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pend_d[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic                  hit;
    rd_pend = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a   = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == a)) hit = 1'b1;
        end
      end
      rd_pend[p] = en & pend_q[a] & ~hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV32 integer register file with bypass, zero entry, clear sequencer and scoreboard.
module regfile_mp import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus,
  output state_e       dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || NUM_RD < 1 || NUM_RD > 4 ||
      NUM_WR < 1 || NUM_WR > 2 || ZERO_REG < 0 || ZERO_REG > 1 ||
      BYPASS < 0 || BYPASS > 1) begin : g_bad_param
    $error("regfile_mp: parameter out of range");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic                    run;
  logic [NUM_WR-1:0]       wr_ok;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;

  // Reset is treated as busy even if the state register still holds RUN.
  assign run = (state_q == RUN) && !rst;

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      a        = bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      wr_ok[w] = run & bus.wr_en[w] &
                 ~((ZERO_REG != 0) && (a == ADDR_WIDTH'(ZERO_IDX)));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == '1) state_d = RUN;
    end
  end

  // Ascending port loop makes the highest enabled port win on an address clash.
  always_comb begin
    mem_d = mem_q;
    if (state_q == INIT) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w])
          mem_d[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] v;
    rd_data_c = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      v = mem_q[a];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == a))
            v = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if ((ZERO_REG != 0) && (a == ADDR_WIDTH'(ZERO_IDX))) v = '0;
      if (!run) v = '0;
      rd_data_c[p*DATA_WIDTH +: DATA_WIDTH] = v;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .pend_set  (bus.pend_set),
    .pend_addr (bus.pend_addr),
    .wr_ok     (wr_ok),
    .wr_addr   (bus.wr_addr),
    .rd_addr   (bus.rd_addr),
    .rd_pend   (bus.rd_pend)
  );

  assign bus.rd_data   = rd_data_c;
  assign bus.init_busy = !run;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports): driver pushes expectations, monitor compares.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int EW     = 1 + NUM_RD + NUM_RD*DW;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            vectors     = 0;
  int            miscompares = 0;

  regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  regfile_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (1),
    .BYPASS     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    rst           = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.pend_set  = 1'b0;
    bus.pend_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en[port]              = 1'b1;
    bus.wr_addr[port*AW +: AW]   = a;
    bus.wr_data[port*DW +: DW]   = d;
  endtask

  task automatic mark(input logic [AW-1:0] a);
    bus.pend_set  = 1'b1;
    bus.pend_addr = a;
  endtask

  task automatic expect_v(input string nm, input logic eb, input logic [1:0] ep,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    exp_q.push_back({eb, ep, e1, e0});
    name_q.push_back(nm);
  endtask

  task automatic reset_pulse();
    tick();
    rst = 1'b1;
    rd(5, 7);
    expect_v("rst_busy", 1'b1, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic busy_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rd(AW'(i), AW'(31 - i));
      expect_v("init_busy", 1'b1, 2'b00, 32'h0, 32'h0);
    end
  endtask

  task automatic expect_ready();
    tick();
    rd(0, 1);
    expect_v("init_done", 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    string         nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.init_busy, bus.rd_pend, bus.rd_data};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got busy=%0b pend=%b d1=%h d0=%h, want busy=%0b pend=%b d1=%h d0=%h",
                 nm, act[EW-1], act[EW-2 -: NUM_RD], act[2*DW-1:DW], act[DW-1:0],
                 e[EW-1], e[EW-2 -: NUM_RD], e[2*DW-1:DW], e[DW-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;

    // power-on clear: busy for exactly 32 cycles, then every entry reads zero
    reset_pulse();
    busy_cycles(32);
    expect_ready();
    for (int i = 0; i < 16; i++) begin
      tick();
      rd(AW'(2*i), AW'(2*i + 1));
      expect_v("clear_zero", 1'b0, 2'b00, 32'h0, 32'h0);
    end

    // write then read on both ports; no bypass hit in the write cycle
    tick(); wr(0, 5, 32'hDEADBEEF); rd(1, 2);
    expect_v("wr_x5", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); rd(5, 5);
    expect_v("rd_x5", 1'b0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF);

    // entry 0 is hardwired
    tick(); wr(0, 0, 32'h1); rd(0, 0);
    expect_v("wr_x0_bypass", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); rd(0, 5);
    expect_v("rd_x0", 1'b0, 2'b00, 32'h0, 32'hDEADBEEF);

    // same-cycle bypass
    tick(); wr(0, 7, 32'h12345678); rd(7, 5);
    expect_v("bypass_x7", 1'b0, 2'b00, 32'h12345678, 32'hDEADBEEF);
    tick(); rd(7, 7);
    expect_v("rd_x7", 1'b0, 2'b00, 32'h12345678, 32'h12345678);

    // dual write, same address: port 1 wins (bypass and storage)
    tick(); wr(0, 3, 32'hAA); wr(1, 3, 32'hBB); rd(3, 3);
    expect_v("dual_bypass", 1'b0, 2'b00, 32'hBB, 32'hBB);
    tick(); rd(3, 3);
    expect_v("dual_x3", 1'b0, 2'b00, 32'hBB, 32'hBB);

    // dual write, distinct addresses
    tick(); wr(0, 10, 32'h1010); wr(1, 11, 32'h1111); rd(10, 11);
    expect_v("dual_split_bypass", 1'b0, 2'b00, 32'h1010, 32'h1111);
    tick(); rd(11, 10);
    expect_v("dual_split_rd", 1'b0, 2'b00, 32'h1111, 32'h1010);

    // scoreboard: set, set+write (set wins), later write clears
    tick(); mark(9); rd(9, 9);
    expect_v("pend_set_cycle", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); rd(9, 8);
    expect_v("pend_visible", 1'b0, 2'b01, 32'h0, 32'h0);
    tick(); mark(9); wr(0, 9, 32'h99); rd(9, 9);
    expect_v("pend_bypass_hide", 1'b0, 2'b00, 32'h99, 32'h99);
    tick(); rd(9, 9);
    expect_v("pend_set_wins", 1'b0, 2'b11, 32'h99, 32'h99);
    tick(); wr(1, 9, 32'h9A); rd(9, 4);
    expect_v("pend_clear_write", 1'b0, 2'b00, 32'h9A, 32'h0);
    tick(); rd(4, 9);
    expect_v("pend_cleared", 1'b0, 2'b00, 32'h0, 32'h9A);
    tick(); mark(0); rd(0, 0);
    expect_v("pend_x0_set", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); rd(0, 9);
    expect_v("pend_x0_never", 1'b0, 2'b00, 32'h0, 32'h9A);

    // reset mid-RUN with a pending register and written data
    tick(); mark(12); rd(12, 5);
    expect_v("pend_x12_set", 1'b0, 2'b00, 32'h0, 32'hDEADBEEF);
    tick(); rd(12, 5);
    expect_v("pend_x12", 1'b0, 2'b01, 32'h0, 32'hDEADBEEF);
    reset_pulse();
    busy_cycles(32);
    expect_ready();
    tick(); rd(12, 5);
    expect_v("run_rst_clear", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); rd(9, 3);
    expect_v("run_rst_clear2", 1'b0, 2'b00, 32'h0, 32'h0);

    // reset mid-INIT restarts the full 32-cycle clear; last INIT cycle ignores write/mark
    reset_pulse();
    busy_cycles(10);
    reset_pulse();
    busy_cycles(31);
    tick(); wr(0, 5, 32'hFFFF); mark(6); rd(5, 6);
    expect_v("init_ignore", 1'b1, 2'b00, 32'h0, 32'h0);
    expect_ready();
    tick(); rd(5, 6);
    expect_v("init_ignored_effects", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); rd(7, 11);
    expect_v("init_restart_zero", 1'b0, 2'b00, 32'h0, 32'h0);

    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d queued expectations, want 0", exp_q.size());
      $fatal(1, "drain");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
